// File: rtl/day5_stream_feeder_if.sv
// Byte stream carrying the raw day-5 puzzle text into the feeder.
interface day5_stream_feeder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/day5_stream_feeder.sv
// ASCII-to-array driver for the day-5 range-check systolic array.
// Parses "S-E" range lines, a blank separator, then "N" id lines, one byte
// per cycle. Pads unused PEs with an empty range, drains the pipeline and
// raises a sticky done once the array count is final.
module day5_stream_feeder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 183,
    parameter int unsigned CNT_W = $clog2(DEPTH + 2)
) (
    input  logic                 clock,
    input  logic                 reset,
    day5_stream_feeder_if.slave  byte_if,
    output logic                 load_ranges,
    output logic [WIDTH-1:0]     start_range,
    output logic [WIDTH-1:0]     end_range,
    output logic [WIDTH-1:0]     id,
    output logic [CNT_W-1:0]     ranges_loaded,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        R_START,
        R_END,
        ID,
        PAD,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_NL   = 8'h0A;
    localparam logic [7:0] CH_DASH = 8'h2D;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             digits_q, digits_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_ranges_q, load_ranges_d;
    logic [WIDTH-1:0] start_range_q, start_range_d;
    logic [WIDTH-1:0] end_range_q, end_range_d;
    logic [WIDTH-1:0] id_q, id_d;
    logic [CNT_W-1:0] ranges_loaded_q, ranges_loaded_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             byte_ready_q, byte_ready_d;

    logic             xfer;
    logic             is_digit;
    logic             is_nl;
    logic             eol;
    logic [WIDTH-1:0] acc_next;

    // Next-state, parse and emit logic; every output is taken from a flop.
    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        start_d         = start_q;
        digits_d        = digits_q;
        last_d          = last_q;
        cnt_d           = cnt_q;
        load_ranges_d   = 1'b0;
        start_range_d   = start_range_q;
        end_range_d     = end_range_q;
        id_d            = '1;
        ranges_loaded_d = ranges_loaded_q;
        done_d          = done_q;
        error_d         = error_q;
        eol             = 1'b0;

        xfer     = byte_if.byte_valid && byte_ready_q;
        is_digit = (byte_if.byte_data >= CH_0) && (byte_if.byte_data <= CH_9);
        is_nl    = (byte_if.byte_data == CH_NL);
        // acc*10 + digit, wrapping mod 2^WIDTH
        acc_next = (acc_q << 3) + (acc_q << 1) + WIDTH'(byte_if.byte_data[3:0]);

        case (state_q)
            R_START, R_END, ID: begin
                if (xfer) begin
                    if (is_digit) begin
                        acc_d    = acc_next;
                        digits_d = 1'b1;
                    end else if (byte_if.byte_data == CH_CR) begin
                        acc_d = acc_q;
                    end else if (byte_if.byte_data == CH_DASH && state_q == R_START) begin
                        start_d  = acc_q;
                        acc_d    = '0;
                        digits_d = 1'b0;
                        state_d  = R_END;
                    end else if (is_nl) begin
                        eol = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end

                    // the final byte closes any open line as if '\n' followed
                    if (byte_if.byte_last) begin
                        eol = 1'b1;
                    end

                    if (eol) begin
                        last_d = byte_if.byte_last;
                        case (state_d)
                            R_START: begin
                                // a bare number without '-' is malformed
                                if (digits_d) begin
                                    error_d = 1'b1;
                                end
                                if (!digits_d || byte_if.byte_last) begin
                                    state_d = PAD;
                                    cnt_d   = CNT_W'(DEPTH) - ranges_loaded_q;
                                end
                                acc_d    = '0;
                                digits_d = 1'b0;
                            end
                            R_END: begin
                                if (is_nl || digits_d) begin
                                    if (ranges_loaded_q == CNT_W'(DEPTH)) begin
                                        error_d = 1'b1;
                                    end else begin
                                        load_ranges_d   = 1'b1;
                                        start_range_d   = start_q;
                                        end_range_d     = acc_d;
                                        ranges_loaded_d = ranges_loaded_q + CNT_W'(1);
                                    end
                                end
                                acc_d    = '0;
                                digits_d = 1'b0;
                                if (byte_if.byte_last) begin
                                    state_d = PAD;
                                    cnt_d   = CNT_W'(DEPTH) - ranges_loaded_d;
                                end else begin
                                    state_d = R_START;
                                end
                            end
                            ID: begin
                                if (digits_d) begin
                                    id_d     = acc_d;
                                    acc_d    = '0;
                                    digits_d = 1'b0;
                                end
                                if (byte_if.byte_last) begin
                                    state_d = DRAIN;
                                    cnt_d   = CNT_W'(DEPTH);
                                end
                            end
                            default: begin
                                state_d = state_q;
                            end
                        endcase
                    end
                end
            end
            PAD: begin
                if (cnt_q != '0) begin
                    // empty range: start above end matches no id
                    load_ranges_d = 1'b1;
                    start_range_d = '1;
                    end_range_d   = '0;
                    cnt_d         = cnt_q - CNT_W'(1);
                end else begin
                    // the last pad load is already on the outputs, hence DEPTH-1
                    state_d = last_q ? DRAIN : ID;
                    cnt_d   = CNT_W'(DEPTH - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = R_START;
            end
        endcase

        byte_ready_d = (state_d == R_START) || (state_d == R_END) || (state_d == ID);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= R_START;
            acc_q           <= '0;
            start_q         <= '0;
            digits_q        <= 1'b0;
            last_q          <= 1'b0;
            cnt_q           <= '0;
            load_ranges_q   <= 1'b0;
            start_range_q   <= '0;
            end_range_q     <= '0;
            id_q            <= '1;
            ranges_loaded_q <= '0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            byte_ready_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            start_q         <= start_d;
            digits_q        <= digits_d;
            last_q          <= last_d;
            cnt_q           <= cnt_d;
            load_ranges_q   <= load_ranges_d;
            start_range_q   <= start_range_d;
            end_range_q     <= end_range_d;
            id_q            <= id_d;
            ranges_loaded_q <= ranges_loaded_d;
            done_q          <= done_d;
            error_q         <= error_d;
            byte_ready_q    <= byte_ready_d;
        end
    end

    assign byte_if.byte_ready = byte_ready_q;
    assign load_ranges        = load_ranges_q;
    assign start_range        = start_range_q;
    assign end_range          = end_range_q;
    assign id                 = id_q;
    assign ranges_loaded      = ranges_loaded_q;
    assign done               = done_q;
    assign error              = error_q;

endmodule

// File: tb/tb_day5_stream_feeder.sv
// Directed bench for day5_stream_feeder with DEPTH=4, WIDTH=64.
module tb_day5_stream_feeder;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam string T1 = "3-5\n10-14\n16-20\n12-18\n\n1\n5\n8\n11\n17\n32\n";

    logic        clock = 1'b0;
    logic        reset;
    logic        load_ranges;
    logic [63:0] start_range;
    logic [63:0] end_range;
    logic [63:0] id;
    logic [2:0]  ranges_loaded;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    day5_stream_feeder_if bif ();

    day5_stream_feeder #(
        .WIDTH (64),
        .DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .byte_if       (bif.slave),
        .load_ranges   (load_ranges),
        .start_range   (start_range),
        .end_range     (end_range),
        .id            (id),
        .ranges_loaded (ranges_loaded),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    // Observation records, written only by the monitor below.
    int          cyc = 0;
    logic [63:0] ld_s [$];
    logic [63:0] ld_e [$];
    logic [63:0] ids_q [$];
    int          last_id_cyc = 0;
    int          last_load_cyc = 0;
    int          done_cyc = 0;
    int          overlap = 0;
    logic        done_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (load_ranges) begin
            ld_s.push_back(start_range);
            ld_e.push_back(end_range);
            last_load_cyc = cyc;
        end
        if (id !== ONES) begin
            ids_q.push_back(id);
            last_id_cyc = cyc;
            if (load_ranges) overlap++;
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    // Array model: ids falling inside any loaded range since the given marks.
    function automatic int fresh_count(input int bl, input int bi);
        int c = 0;
        for (int k = bi; k < ids_q.size(); k++) begin
            bit hit = 1'b0;
            for (int j = bl; j < ld_s.size(); j++)
                if (ld_s[j] <= ids_q[k] && ids_q[k] <= ld_e[j]) hit = 1'b1;
            if (hit) c++;
        end
        return c;
    endfunction

    task automatic apply_reset();
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic send(input string s, input bit gaps, input bit last);
        int n;
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 0; g++) begin
                    bif.byte_valid = 1'b0;
                    bif.byte_last  = 1'b0;
                    @(posedge clock); #1;
                end
            end
            bif.byte_valid = 1'b1;
            bif.byte_data  = s[i];
            bif.byte_last  = last && (i == s.len() - 1);
            n = 0;
            while (!bif.byte_ready && n < 200) begin @(posedge clock); #1; n++; end
            if (!bif.byte_ready) begin
                checks++; errors++;
                $display("FAIL send_ready: byte_ready=0 required=1 at char %0d", i);
                bif.byte_valid = 1'b0;
                bif.byte_last  = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;
    endtask

    task automatic test_reset();
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;
        bif.byte_data  = 8'h00;
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        checks++; if (load_ranges !== 1'b0) begin errors++; $display("FAIL rst_load: got %0b required 0", load_ranges); end
        checks++; if (start_range !== 64'd0) begin errors++; $display("FAIL rst_start: got %0h required 0", start_range); end
        checks++; if (end_range !== 64'd0) begin errors++; $display("FAIL rst_end: got %0h required 0", end_range); end
        checks++; if (id !== ONES) begin errors++; $display("FAIL rst_id: got %0h required all-ones", id); end
        checks++; if (ranges_loaded !== 3'd0) begin errors++; $display("FAIL rst_loaded: got %0d required 0", ranges_loaded); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_flags: done=%0b error=%0b required 0 0", done, error); end
        reset = 1'b0;
        checks++; if (bif.byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_lo: got %0b required 0", bif.byte_ready); end
        @(posedge clock); #1;
        checks++; if (bif.byte_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_hi: got %0b required 1", bif.byte_ready); end
    endtask

    task automatic test_full(input bit gaps);
        logic [63:0] es [$];
        logic [63:0] ee [$];
        logic [63:0] ei [$];
        int bl, bi, bo, n;
        bit ok;
        es = '{64'd3, 64'd10, 64'd16, 64'd12};
        ee = '{64'd5, 64'd14, 64'd20, 64'd18};
        ei = '{64'd1, 64'd5, 64'd8, 64'd11, 64'd17, 64'd32};
        apply_reset();
        bl = ld_s.size(); bi = ids_q.size(); bo = overlap;
        send(T1, gaps, 1'b1);
        n = 0;
        while (!done && n < 100) begin @(posedge clock); #1; n++; end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done g=%0b: got %0b required 1", gaps, done); end
        ok = (ld_s.size() - bl == es.size());
        for (int i = 0; ok && i < es.size(); i++)
            if (ld_s[bl+i] !== es[i] || ld_e[bl+i] !== ee[i]) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL full_loads g=%0b: got %0d loads required 4 (3/5 10/14 16/20 12/18)", gaps, ld_s.size() - bl); end
        ok = (ids_q.size() - bi == ei.size());
        for (int i = 0; ok && i < ei.size(); i++)
            if (ids_q[bi+i] !== ei[i]) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL full_ids g=%0b: got %0d ids required 6 (1 5 8 11 17 32)", gaps, ids_q.size() - bi); end
        checks++; if (done_cyc - last_id_cyc !== 5) begin errors++; $display("FAIL full_drain g=%0b: got %0d cycles required 5", gaps, done_cyc - last_id_cyc); end
        checks++; if (fresh_count(bl, bi) !== 3) begin errors++; $display("FAIL full_fresh g=%0b: got %0d required 3", gaps, fresh_count(bl, bi)); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL full_error g=%0b: got %0b required 0", gaps, error); end
        checks++; if (ranges_loaded !== 3'd4) begin errors++; $display("FAIL full_loaded g=%0b: got %0d required 4", gaps, ranges_loaded); end
        checks++; if (overlap - bo !== 0) begin errors++; $display("FAIL full_overlap g=%0b: got %0d required 0", gaps, overlap - bo); end
        checks++; if (bif.byte_ready !== 1'b0) begin errors++; $display("FAIL full_ready_done g=%0b: got %0b required 0", gaps, bif.byte_ready); end
    endtask

    task automatic test_pad(input bit do_reset);
        int bl, bi, n;
        bit ok;
        if (do_reset) apply_reset();
        bl = ld_s.size(); bi = ids_q.size();
        send("3-5\n\n4\n", 1'b0, 1'b1);
        n = 0;
        while (!done && n < 100) begin @(posedge clock); #1; n++; end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pad_done r=%0b: got %0b required 1", do_reset, done); end
        ok = (ld_s.size() - bl == 4);
        if (ok) ok = (ld_s[bl] === 64'd3 && ld_e[bl] === 64'd5);
        for (int i = 1; ok && i < 4; i++)
            if (ld_s[bl+i] !== ONES || ld_e[bl+i] !== 64'd0) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL pad_loads r=%0b: got %0d loads required 4 (3/5 then 3 pads)", do_reset, ld_s.size() - bl); end
        ok = (ids_q.size() - bi == 1);
        if (ok) ok = (ids_q[bi] === 64'd4);
        checks++; if (!ok) begin errors++; $display("FAIL pad_ids r=%0b: got %0d ids required 1 (4)", do_reset, ids_q.size() - bi); end
        checks++; if (ranges_loaded !== 3'd1) begin errors++; $display("FAIL pad_loaded r=%0b: got %0d required 1", do_reset, ranges_loaded); end
        checks++; if (fresh_count(bl, bi) !== 1) begin errors++; $display("FAIL pad_fresh r=%0b: got %0d required 1", do_reset, fresh_count(bl, bi)); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL pad_error r=%0b: got %0b required 0", do_reset, error); end
        checks++; if (done_cyc - last_id_cyc !== 5) begin errors++; $display("FAIL pad_drain r=%0b: got %0d required 5", do_reset, done_cyc - last_id_cyc); end
    endtask

    task automatic test_overflow();
        int bl, bi, n;
        bit ok;
        apply_reset();
        bl = ld_s.size(); bi = ids_q.size();
        send("1-2\n3-4\n5-6\n7-8\n", 1'b0, 1'b0);
        @(posedge clock); #1;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_error_pre: got %0b required 0", error); end
        checks++; if (ranges_loaded !== 3'd4) begin errors++; $display("FAIL ovf_loaded_pre: got %0d required 4", ranges_loaded); end
        send("9-10\n", 1'b0, 1'b0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %0b required 1", error); end
        send("\n7\n", 1'b0, 1'b1);
        n = 0;
        while (!done && n < 100) begin @(posedge clock); #1; n++; end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %0b required 1", done); end
        ok = (ld_s.size() - bl == 4);
        for (int i = 0; ok && i < 4; i++)
            if (ld_s[bl+i] !== 64'(2*i + 1) || ld_e[bl+i] !== 64'(2*i + 2)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL ovf_loads: got %0d loads required 4 (1/2 3/4 5/6 7/8)", ld_s.size() - bl); end
        ok = (ids_q.size() - bi == 1);
        if (ok) ok = (ids_q[bi] === 64'd7);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_ids: got %0d ids required 1 (7)", ids_q.size() - bi); end
        checks++; if (ranges_loaded !== 3'd4) begin errors++; $display("FAIL ovf_loaded: got %0d required 4", ranges_loaded); end
    endtask

    task automatic test_last();
        int bl, bi, n;
        bit ok;
        apply_reset();
        bl = ld_s.size(); bi = ids_q.size();
        send("3-5\n\n42", 1'b0, 1'b1);
        n = 0;
        while (!done && n < 100) begin @(posedge clock); #1; n++; end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL last_done: got %0b required 1", done); end
        ok = (ids_q.size() - bi == 1);
        if (ok) ok = (ids_q[bi] === 64'd42);
        checks++; if (!ok) begin errors++; $display("FAIL last_ids: got %0d ids required 1 (42)", ids_q.size() - bi); end
        checks++; if (ld_s.size() - bl !== 4) begin errors++; $display("FAIL last_loads: got %0d required 4", ld_s.size() - bl); end
        checks++; if (done_cyc - last_id_cyc !== 5) begin errors++; $display("FAIL last_drain: got %0d required 5", done_cyc - last_id_cyc); end

        apply_reset();
        bl = ld_s.size(); bi = ids_q.size();
        send("1x-2\n", 1'b0, 1'b1);
        n = 0;
        while (!done && n < 100) begin @(posedge clock); #1; n++; end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL badch_done: got %0b required 1", done); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badch_error: got %0b required 1", error); end
        ok = (ld_s.size() - bl == 4);
        if (ok) ok = (ld_s[bl] === 64'd1 && ld_e[bl] === 64'd2);
        for (int i = 1; ok && i < 4; i++)
            if (ld_s[bl+i] !== ONES || ld_e[bl+i] !== 64'd0) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL badch_loads: got %0d loads required 4 (1/2 then 3 pads)", ld_s.size() - bl); end
        checks++; if (ids_q.size() - bi !== 0) begin errors++; $display("FAIL badch_ids: got %0d ids required 0", ids_q.size() - bi); end
        checks++; if (done_cyc - last_load_cyc !== 5) begin errors++; $display("FAIL badch_drain: got %0d required 5", done_cyc - last_load_cyc); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        send("3-5\n10-14\n16-20\n12-18\n\n1\n5\n", 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (load_ranges !== 1'b0 || id !== ONES) begin errors++; $display("FAIL mid_outs: load=%0b id=%0h required 0 all-ones", load_ranges, id); end
        checks++; if (start_range !== 64'd0 || end_range !== 64'd0) begin errors++; $display("FAIL mid_bounds: start=%0h end=%0h required 0 0", start_range, end_range); end
        checks++; if (ranges_loaded !== 3'd0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_state: loaded=%0d done=%0b error=%0b required 0 0 0", ranges_loaded, done, error); end
        checks++; if (bif.byte_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_lo: got %0b required 0", bif.byte_ready); end
        @(posedge clock); #1;
        checks++; if (bif.byte_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_hi: got %0b required 1", bif.byte_ready); end
        test_pad(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_full(1'b0);
        test_pad(1'b1);
        test_overflow();
        test_full(1'b1);
        test_last();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
